// File: rtl/d_mem_port_arbiter_if.sv
// Core-side request/response bus and memory-side bus of the N-core data-memory arbiter.
// slave is the arbiter's view; master is the view of the cores plus memory that surround it.
interface d_mem_port_arbiter_if #(
  parameter int NUM_CORES       = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 32,
  parameter int MAX_OUTSTANDING = 4
);
  logic [NUM_CORES-1:0]                core_read;
  logic [NUM_CORES-1:0]                core_write;
  logic [NUM_CORES*DATA_WIDTH/8-1:0]   core_byte_en;
  logic [NUM_CORES*ADDRESS_BITS-1:0]   core_address_in;
  logic [NUM_CORES*DATA_WIDTH-1:0]     core_data_in;
  logic [NUM_CORES-1:0]                core_ready;
  logic [NUM_CORES-1:0]                core_valid;
  logic [DATA_WIDTH-1:0]               core_data_out;
  logic [ADDRESS_BITS-1:0]             core_address_out;

  logic                                mem_read;
  logic                                mem_write;
  logic [DATA_WIDTH/8-1:0]             mem_byte_en;
  logic [ADDRESS_BITS-1:0]             mem_address_in;
  logic [DATA_WIDTH-1:0]               mem_data_in;
  logic                                mem_ready;
  logic [DATA_WIDTH-1:0]               mem_data_out;
  logic [ADDRESS_BITS-1:0]             mem_address_out;
  logic                                mem_valid;

  logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding;
  logic                                 rsp_error;

  modport slave (
    input  core_read, core_write, core_byte_en, core_address_in, core_data_in,
    output core_ready, core_valid, core_data_out, core_address_out,
    output mem_read, mem_write, mem_byte_en, mem_address_in, mem_data_in,
    input  mem_ready, mem_data_out, mem_address_out, mem_valid,
    output outstanding, rsp_error
  );

  modport master (
    output core_read, core_write, core_byte_en, core_address_in, core_data_in,
    input  core_ready, core_valid, core_data_out, core_address_out,
    input  mem_read, mem_write, mem_byte_en, mem_address_in, mem_data_in,
    output mem_ready, mem_data_out, mem_address_out, mem_valid,
    input  outstanding, rsp_error
  );
endinterface

// File: rtl/d_mem_port_arbiter.sv
// Round-robin N-core data-memory arbiter: 0-cycle request path, 1-cycle read response routing via an in-order tag FIFO.
// Backpressure: no grant while mem_ready=0; reads additionally wait while MAX_OUTSTANDING reads are in flight.
module d_mem_port_arbiter_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign pop_dat = slots[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) slots[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally at DEPTH (power of two); fullness comes from count only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module d_mem_port_arbiter #(
  parameter int NUM_CORES       = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clock,
  input  logic            reset,
  d_mem_port_arbiter_if.slave bus
);
  localparam int TW = $clog2(NUM_CORES);
  localparam int BW = DATA_WIDTH / 8;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [TW-1:0]        rr_ptr;
  logic [OW-1:0]        occupancy;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [TW-1:0]        head_tag;
  logic [NUM_CORES-1:0] grantable;
  logic                 grant_any;
  logic [TW-1:0]        grant_idx;
  logic                 grant_is_read;
  logic                 push;
  logic                 pop;

  assign fifo_full  = (occupancy == OW'(MAX_OUTSTANDING));
  assign fifo_empty = (occupancy == '0);

  // A read-only requester is skipped while the tag FIFO is full so writers behind it still proceed.
  always_comb begin
    grantable = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      grantable[i] = bus.mem_ready & (bus.core_write[i] | (bus.core_read[i] & ~fifo_full));
    end
  end

  always_comb begin : rr_search
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!grant_any && grantable[idx]) begin
        grant_any = 1'b1;
        grant_idx = TW'(idx);
      end
    end
  end

  assign grant_is_read = grant_any & bus.core_read[grant_idx] & ~bus.core_write[grant_idx];
  assign push          = grant_is_read;
  assign pop           = bus.mem_valid & ~fifo_empty;

  always_comb begin
    bus.core_ready     = '0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_byte_en    = '0;
    bus.mem_address_in = '0;
    bus.mem_data_in    = '0;
    if (grant_any) begin
      bus.core_ready[grant_idx] = 1'b1;
      bus.mem_read              = grant_is_read;
      bus.mem_write             = bus.core_write[grant_idx];
      bus.mem_byte_en           = bus.core_byte_en[int'(grant_idx)*BW +: BW];
      bus.mem_address_in        = bus.core_address_in[int'(grant_idx)*ADDRESS_BITS +: ADDRESS_BITS];
      bus.mem_data_in           = bus.core_data_in[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  d_mem_port_arbiter_fifo #(
    .WIDTH (TW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat (grant_idx),
    .pop      (pop),
    .pop_dat  (head_tag),
    .count    (occupancy)
  );

  assign bus.outstanding = occupancy;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr               <= '0;
      bus.core_valid       <= '0;
      bus.core_data_out    <= '0;
      bus.core_address_out <= '0;
      bus.rsp_error        <= 1'b0;
    end else begin
      if (grant_any) begin
        rr_ptr <= (grant_idx == TW'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
      end
      bus.core_valid <= '0;
      if (pop) begin
        bus.core_valid[head_tag] <= 1'b1;
        bus.core_data_out        <= bus.mem_data_out;
        bus.core_address_out     <= bus.mem_address_out;
      end
      // A response with nothing in flight has no owner; it is dropped and flagged.
      if (bus.mem_valid && fifo_empty) bus.rsp_error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_d_mem_port_arbiter.sv
// Scoreboard bench for d_mem_port_arbiter (4 cores, 4 outstanding): directed scenarios plus random traffic
// against a queue-based reference model; a separate monitor checks routed read responses.
module tb_d_mem_port_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AB = 32;
  localparam int MO = 4;

  logic clk;
  logic rst_n;

  d_mem_port_arbiter_if #(.NUM_CORES(N), .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .MAX_OUTSTANDING(MO)) bus ();

  d_mem_port_arbiter #(.NUM_CORES(N), .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .MAX_OUTSTANDING(MO)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [31:0] dat;
    logic [31:0] adr;
    int          due;
  } rsp_t;

  int          tests  = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          m_rr   = 0;
  logic        m_err  = 1'b0;
  int          tagq[$];
  rsp_t        exp_rsp[$];
  int          gcount[N];
  logic [31:0] cur_addr[N];
  logic [31:0] cur_data[N];
  logic [3:0]  cur_be[N];
  int          pin_core = -1;
  logic [31:0] pin_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // First core at or after m_rr that may be served now: writers need mem_ready, readers also need a free tag slot.
  function automatic int model_grant(input logic [3:0] rd, input logic [3:0] wr, input logic mrdy);
    int g;
    int idx;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_rr + k) % N;
      if (g < 0 && mrdy && (wr[idx] || (rd[idx] && tagq.size() < MO))) g = idx;
    end
    return g;
  endfunction

  task automatic set_idle();
    bus.core_read       = '0;
    bus.core_write      = '0;
    bus.core_byte_en    = '0;
    bus.core_address_in = '0;
    bus.core_data_in    = '0;
    bus.mem_ready       = 1'b0;
    bus.mem_valid       = 1'b0;
    bus.mem_data_out    = '0;
    bus.mem_address_out = '0;
  endtask

  // Entered and left at posedge+1: drives one cycle, checks the request path at negedge, advances the model.
  task automatic run_cycle(input logic [3:0] rd, input logic [3:0] wr, input logic mrdy,
                           input logic mvld, input logic [31:0] mdat, input logic [31:0] madr);
    int          g;
    rsp_t        r;
    logic        e_rd, e_wr;
    logic [3:0]  e_be, e_rdy;
    logic [31:0] e_a, e_d;
    for (int i = 0; i < N; i++) begin
      cur_addr[i] = $urandom;
      cur_data[i] = $urandom;
      cur_be[i]   = 4'($urandom);
    end
    if (pin_core >= 0) cur_addr[pin_core] = pin_addr;
    for (int i = 0; i < N; i++) begin
      bus.core_address_in[i*AB +: AB] = cur_addr[i];
      bus.core_data_in[i*DW +: DW]    = cur_data[i];
      bus.core_byte_en[i*4 +: 4]      = cur_be[i];
    end
    bus.core_read       = rd;
    bus.core_write      = wr;
    bus.mem_ready       = mrdy;
    bus.mem_valid       = mvld;
    bus.mem_data_out    = mdat;
    bus.mem_address_out = madr;
    @(negedge clk);
    g = model_grant(rd, wr, mrdy);
    chk("outstanding", 64'(bus.outstanding), 64'(tagq.size()));
    chk("rsp_error", 64'(bus.rsp_error), 64'(m_err));
    e_rd = 1'b0; e_wr = 1'b0; e_be = '0; e_a = '0; e_d = '0; e_rdy = '0;
    if (g >= 0) begin
      e_rdy = 4'(1 << g);
      e_wr  = wr[g];
      e_rd  = rd[g] & ~wr[g];
      e_be  = cur_be[g];
      e_a   = cur_addr[g];
      e_d   = cur_data[g];
    end
    chk("core_ready", 64'(bus.core_ready), 64'(e_rdy));
    chk("mem_read", 64'(bus.mem_read), 64'(e_rd));
    chk("mem_write", 64'(bus.mem_write), 64'(e_wr));
    chk("mem_byte_en", 64'(bus.mem_byte_en), 64'(e_be));
    chk("mem_address_in", 64'(bus.mem_address_in), 64'(e_a));
    chk("mem_data_in", 64'(bus.mem_data_in), 64'(e_d));
    for (int i = 0; i < N; i++) if (bus.core_ready[i]) gcount[i]++;
    if (mvld) begin
      if (tagq.size() > 0) begin
        r.tag = tagq.pop_front();
        r.dat = mdat;
        r.adr = madr;
        r.due = cyc + 1;
        exp_rsp.push_back(r);
      end else begin
        m_err = 1'b1;
      end
    end
    if (g >= 0) begin
      if (rd[g] && !wr[g]) tagq.push_back(g);
      m_rr = (g + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(4'h0, 4'h0, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2*MO && tagq.size() > 0; i++) run_cycle(4'h0, 4'h0, 1'b1, 1'b1, $urandom, $urandom);
  endtask

  task automatic chk_reset_regs(input string tag);
    chk({tag, "_core_valid"}, 64'(bus.core_valid), 64'h0);
    chk({tag, "_core_data_out"}, 64'(bus.core_data_out), 64'h0);
    chk({tag, "_core_address_out"}, 64'(bus.core_address_out), 64'h0);
    chk({tag, "_outstanding"}, 64'(bus.outstanding), 64'h0);
    chk({tag, "_rsp_error"}, 64'(bus.rsp_error), 64'h0);
  endtask

  // Response monitor: every core_valid pulse must match the oldest expected response, on its due cycle.
  always @(negedge clk) begin
    rsp_t r;
    if (bus.core_valid != '0) begin
      if (exp_rsp.size() == 0) begin
        chk("rsp_unexpected", 64'(bus.core_valid), 64'h0);
      end else begin
        r = exp_rsp.pop_front();
        chk("rsp_core_valid", 64'(bus.core_valid), 64'(1 << r.tag));
        chk("rsp_data", 64'(bus.core_data_out), 64'(r.dat));
        chk("rsp_address", 64'(bus.core_address_out), 64'(r.adr));
        chk("rsp_latency", 64'(cyc), 64'(r.due));
      end
    end else if (exp_rsp.size() > 0 && exp_rsp[0].due <= cyc) begin
      r = exp_rsp.pop_front();
      chk("rsp_missing", 64'(bus.core_valid), 64'(1 << r.tag));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rd, wr;
    logic       mrdy, mvld;
    set_idle();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) gcount[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_regs("reset");
    chk("reset_core_ready", 64'(bus.core_ready), 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single read from core 1 at 0x40, answered three cycles later.
    pin_core = 1; pin_addr = 32'h40;
    run_cycle(4'b0010, 4'h0, 1'b1, 1'b0, '0, '0);
    pin_core = -1;
    chk("single_outstanding", 64'(bus.outstanding), 64'd1);
    idle(2);
    run_cycle(4'h0, 4'h0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h40);
    idle(2);

    // Fairness: all four cores read every cycle for 100 cycles.
    for (int i = 0; i < N; i++) gcount[i] = 0;
    for (int c = 0; c < 100; c++) run_cycle(4'hF, 4'h0, 1'b1, (c > 0), $urandom, $urandom);
    for (int i = 0; i < N; i++) chk($sformatf("fair_core%0d", i), 64'(gcount[i]), 64'd25);
    drain();
    idle(1);

    // Full FIFO: four reads, then a blocked read alongside a core-2 write.
    for (int i = 0; i < MO; i++) run_cycle(4'b0001, 4'h0, 1'b1, 1'b0, '0, '0);
    chk("full_outstanding", 64'(bus.outstanding), 64'd4);
    run_cycle(4'b0001, 4'b0100, 1'b1, 1'b0, '0, '0);
    run_cycle(4'b0001, 4'h0, 1'b1, 1'b1, 32'h11111111, 32'h100);
    run_cycle(4'b0001, 4'h0, 1'b1, 1'b0, '0, '0);
    drain();
    idle(1);

    // Ordering: cores 0,1,0 then three back-to-back responses.
    run_cycle(4'b0001, 4'h0, 1'b1, 1'b0, '0, '0);
    run_cycle(4'b0010, 4'h0, 1'b1, 1'b0, '0, '0);
    run_cycle(4'b0001, 4'h0, 1'b1, 1'b0, '0, '0);
    run_cycle(4'h0, 4'h0, 1'b1, 1'b1, 32'hAAAA0001, 32'hA0);
    run_cycle(4'h0, 4'h0, 1'b1, 1'b1, 32'hBBBB0002, 32'hB0);
    run_cycle(4'h0, 4'h0, 1'b1, 1'b1, 32'hCCCC0003, 32'hC0);
    idle(2);

    // Conflict under backpressure: read+write on core 0 waits, then issues as a write.
    run_cycle(4'b0001, 4'b0001, 1'b0, 1'b0, '0, '0);
    run_cycle(4'b0001, 4'b0001, 1'b0, 1'b0, '0, '0);
    run_cycle(4'b0001, 4'b0001, 1'b1, 1'b0, '0, '0);
    idle(1);

    // Unexpected response sets the sticky error.
    run_cycle(4'h0, 4'h0, 1'b1, 1'b1, 32'h0BAD0BAD, 32'h44);
    idle(2);

    // Mid-burst asynchronous reset with two reads still in flight.
    run_cycle(4'b0100, 4'h0, 1'b1, 1'b0, '0, '0);
    run_cycle(4'b1000, 4'h0, 1'b1, 1'b0, '0, '0);
    run_cycle(4'b0001, 4'h0, 1'b1, 1'b0, '0, '0);
    run_cycle(4'h0, 4'h0, 1'b1, 1'b1, 32'h12345678, 32'hABC);
    rst_n = 1'b0;
    set_idle();
    tagq.delete();
    exp_rsp.delete();
    m_rr  = 0;
    m_err = 1'b0;
    #1;
    chk_reset_regs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_cycle(4'h0, 4'h0, 1'b1, 1'b1, 32'h5555AAAA, 32'h8);
    idle(2);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      rd   = 4'($urandom);
      wr   = 4'($urandom) & 4'($urandom);
      mrdy = ($urandom_range(0, 3) != 0);
      if (tagq.size() > 0) mvld = ($urandom_range(0, 2) != 0);
      else                 mvld = ($urandom_range(0, 15) == 0);
      run_cycle(rd, wr, mrdy, mvld, $urandom, $urandom);
    end
    drain();
    idle(3);
    chk("rsp_drain", 64'(exp_rsp.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/d_mem_port_arbiter.md
# d_mem_port_arbiter

Parametrised N-core data-memory arbiter, the multi-core successor to the single-core top-level memory hookup. It sits between NUM_CORES core data-memory ports and the single data port of the dual-port BRAM memory subsystem. It arbitrates requests round-robin, issues them to memory, and tracks outstanding reads in an in-order tag FIFO. It routes each returned read to the core that issued it.

## Interface
- NUM_CORES, 2, number of requesting cores (≥2)
- DATA_WIDTH, 32, data word width
- ADDRESS_BITS, 32, address width
- MAX_OUTSTANDING, 4, tag FIFO depth (power of two, ≥2)
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- core_read  in  NUM_CORES  per-core read request
- core_write  in  NUM_CORES  per-core write request
- core_byte_en  in  NUM_CORES*DATA_WIDTH/8  per-core byte enables, core i at slice i
- core_address_in  in  NUM_CORES*ADDRESS_BITS  per-core request address
- core_data_in  in  NUM_CORES*DATA_WIDTH  per-core write data
- core_ready  out  NUM_CORES  one-hot grant; request accepted this cycle
- core_valid  out  NUM_CORES  one-hot read-response strobe
- core_data_out  out  DATA_WIDTH  response data, shared by all cores
- core_address_out  out  ADDRESS_BITS  response address, shared by all cores
- mem_read / mem_write  out  1 / 1  issued request to memory
- mem_byte_en  out  DATA_WIDTH/8  issued byte enables
- mem_address_in  out  ADDRESS_BITS  issued address
- mem_data_in  out  DATA_WIDTH  issued write data
- mem_ready  in  1  memory can accept a request this cycle
- mem_data_out / mem_address_out  in  DATA_WIDTH / ADDRESS_BITS  memory response
- mem_valid  in  1  memory response strobe; reads only, in issue order
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  reads in flight
- rsp_error  out  1  sticky; set on an unexpected response

## Operation
- Core i is eligible when core_read[i] or core_write[i] is set.
- If a core asserts both, the write wins and the read is ignored.
- Round-robin pointer rr_ptr: the first eligible core at or after rr_ptr gets the grant, searching upward with wrap-around.
- A grant occurs only if mem_ready=1. For a read it also requires that the FIFO is not full.
- A blocked read does not stall other cores: the search skips it and proceeds to the next eligible writer.
- On grant to core g: core_ready[g]=1, the mem_* request fields carry core g's slices, and rr_ptr ← (g+1) mod NUM_CORES.
- With no grant: mem_read=mem_write=0, core_ready=0, rr_ptr is held, and the mem_* data fields are don't-care (driven 0).
- Each granted read pushes g into the tag FIFO. Writes push nothing.
- On mem_valid with a non-empty FIFO: pop the head h and register the response outputs. Next cycle core_valid[h]=1, and core_data_out / core_address_out carry the memory values.
- On mem_valid with an empty FIFO: the response is dropped, rsp_error ← 1, and no core_valid pulse is produced.
- Push and pop in the same cycle are allowed: occupancy is unchanged. When the FIFO is full, no read is issued, even if a pop occurs that cycle.
- outstanding equals the FIFO occupancy and is registered.
- Reset, asynchronous, including mid-operation:
  - rr_ptr=0, FIFO empty, outstanding=0, rsp_error=0.
  - core_valid=0, core_data_out=0, core_address_out=0.
  - In-flight reads are forgotten. Their later responses set rsp_error.

## Timing
- Request path is combinational: core_ready and mem_* are valid in the same cycle as the request, so request-to-memory latency is 0 cycles.
- core_ready depends only on core_read, core_write, mem_ready and registered state; it has no combinational path from mem_valid.
- Response latency is 1 cycle from mem_valid to core_valid. core_valid is a single-cycle pulse per response.
- Sustained throughput is one request per cycle and one response per cycle.
- The FIFO pointers wrap modulo MAX_OUTSTANDING. Full is indicated by the occupancy counter, not pointer equality alone.

## Test plan
- Single read: core 1 reads 0x40 with mem_ready=1 → cycle 0 core_ready=2'b10, mem_read=1, mem_address_in=0x40, outstanding→1. mem_valid 3 cycles later with data 0xDEADBEEF → next cycle core_valid=2'b10, core_data_out=0xDEADBEEF, outstanding→0.
- Fairness: NUM_CORES=4, all cores read continuously, no backpressure → grants cycle 0,1,2,3,0,… and each core gets exactly 25 of 100 grants.
- Full FIFO: 4 reads issued with no responses → 5th read gets core_ready=0 and outstanding=4. A simultaneous core-2 write is still granted. After one mem_valid, the read is granted on the next cycle.
- Ordering: cores 0,1,0 issue reads A,B,C, then 3 back-to-back mem_valid → core_valid sequence 01,10,01 on consecutive cycles with matching data.
- Error and reset: mem_valid while outstanding=0 → rsp_error=1 and stays set. Assert reset mid-burst with 2 reads outstanding → all outputs 0 and outstanding=0 immediately (asynchronously); rsp_error clears.
- Conflict and backpressure: core 0 asserts read and write together with mem_ready=0 → no grant and rr_ptr held. When mem_ready rises, the grant issues mem_write=1, mem_read=0, and no FIFO push.
